// File: rtl/fu_share_pkg.sv
// rtl/fu_share_pkg.sv - shared constants and helpers for the functional-unit sharing arbiters
package fu_share_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    // Circular wrap of an index that is at most one lap past n.
    function automatic int rr_wrap(input int c, input int n);
        return (c >= n) ? c - n : c;
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return rr_wrap(idx + 1, n);
    endfunction

endpackage

// File: rtl/fu_rr_pick.sv
// rtl/fu_rr_pick.sv - combinational circular priority encoder starting at ptr
module fu_rr_pick
    import fu_share_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          any
);

    // Scan from the farthest offset down so the nearest set bit past ptr wins.
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[rr_wrap(int'(ptr) + i, N)]) begin
                idx = PW'(rr_wrap(int'(ptr) + i, N));
            end
        end
    end

endmodule

// File: rtl/fu_share_arbiter.sv
// rtl/fu_share_arbiter.sv - round-robin sequencer time-sharing one functional unit among N_REQ controllers
module fu_share_arbiter
    import fu_share_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int OP_W   = 2,
    parameter int FU_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] op_a,
    input  logic [N_REQ*DATA_W-1:0] op_b,
    input  logic [N_REQ*OP_W-1:0]   op_code,
    output logic [N_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]       fu_a,
    output logic [DATA_W-1:0]       fu_b,
    output logic [OP_W-1:0]         fu_op,
    output logic                    fu_start,
    input  logic [DATA_W-1:0]       fu_res,
    output logic [DATA_W-1:0]       res_data,
    output logic [N_REQ-1:0]        res_valid,
    output logic                    busy
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(FU_LAT) + 1;

    logic [0:0]        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  res_valid_q, res_valid_d;
    logic              fu_start_q, fu_start_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] fu_a_q, fu_a_d;
    logic [DATA_W-1:0] fu_b_q, fu_b_d;
    logic [OP_W-1:0]   fu_op_q, fu_op_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;

    logic [PW-1:0]     pick_idx;
    logic              pick_any;

    fu_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        res_valid_d = '0;
        fu_start_d  = 1'b0;
        busy_d      = busy_q;
        fu_a_d      = fu_a_q;
        fu_b_d      = fu_b_q;
        fu_op_d     = fu_op_q;
        res_data_d  = res_data_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_d    = pick_idx;
                    fu_a_d     = op_a[pick_idx*DATA_W +: DATA_W];
                    fu_b_d     = op_b[pick_idx*DATA_W +: DATA_W];
                    fu_op_d    = op_code[pick_idx*OP_W +: OP_W];
                    gnt_d      = N_REQ'(1) << pick_idx;
                    fu_start_d = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = CW'(FU_LAT - 1);
                    state_d    = ST_EXEC;
                end
            end
            default: begin
                // Requests are deliberately ignored here; they compete again once back in IDLE.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    res_data_d  = fu_res;
                    res_valid_d = N_REQ'(1) << owner_q;
                    ptr_d       = PW'(rr_next(int'(owner_q), N_REQ));
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            res_valid_q <= '0;
            fu_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            fu_a_q      <= '0;
            fu_b_q      <= '0;
            fu_op_q     <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
            fu_start_q  <= fu_start_d;
            busy_q      <= busy_d;
            fu_a_q      <= fu_a_d;
            fu_b_q      <= fu_b_d;
            fu_op_q     <= fu_op_d;
            res_data_q  <= res_data_d;
        end
    end

    assign gnt       = gnt_q;
    assign res_valid = res_valid_q;
    assign fu_start  = fu_start_q;
    assign busy      = busy_q;
    assign fu_a      = fu_a_q;
    assign fu_b      = fu_b_q;
    assign fu_op     = fu_op_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_fu_share_arbiter.sv
// tb/tb_fu_share_arbiter.sv - directed bench for fu_share_arbiter with a 3-cycle multiplier and a 1-cycle adder
module tb_fu_share_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  req3 = '0, gnt3, res_valid3;
    logic [63:0] a3 = '0, b3 = '0;
    logic [7:0]  op3 = '0;
    logic [15:0] fu_a3, fu_b3, fu_res3, res_data3;
    logic [1:0]  fu_op3;
    logic        fu_start3, busy3;

    logic [3:0]  req1 = '0, gnt1, res_valid1;
    logic [63:0] a1 = '0, b1 = '0;
    logic [7:0]  op1 = '0;
    logic [15:0] fu_a1, fu_b1, fu_res1, res_data1;
    logic [1:0]  fu_op1;
    logic        fu_start1, busy1;

    assign fu_res3 = fu_a3 * fu_b3;
    assign fu_res1 = fu_a1 + fu_b1;

    fu_share_arbiter #(.N_REQ(4), .DATA_W(16), .OP_W(2), .FU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .op_a(a3), .op_b(b3), .op_code(op3),
        .gnt(gnt3), .fu_a(fu_a3), .fu_b(fu_b3), .fu_op(fu_op3), .fu_start(fu_start3),
        .fu_res(fu_res3), .res_data(res_data3), .res_valid(res_valid3), .busy(busy3)
    );

    fu_share_arbiter #(.N_REQ(4), .DATA_W(16), .OP_W(2), .FU_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .op_a(a1), .op_b(b1), .op_code(op1),
        .gnt(gnt1), .fu_a(fu_a1), .fu_b(fu_b1), .fu_op(fu_op1), .fu_start(fu_start1),
        .fu_res(fu_res1), .res_data(res_data1), .res_valid(res_valid1), .busy(busy1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] oh;
        int order [4];
        order = '{0, 2, 0, 2};

        // Reset state
        tick(); tick();
        chk("rst_gnt", 32'(gnt3), 32'h0);
        chk("rst_res_valid", 32'(res_valid3), 32'h0);
        chk("rst_fu_start", 32'(fu_start3), 32'h0);
        chk("rst_fu_a", 32'(fu_a3), 32'h0);
        chk("rst_fu_b", 32'(fu_b3), 32'h0);
        chk("rst_fu_op", 32'(fu_op3), 32'h0);
        chk("rst_res_data", 32'(res_data3), 32'h0);
        chk("rst_busy", 32'(busy3), 32'h0);
        chk("rst_busy1", 32'(busy1), 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic op: requester 1 computes 3*5
        a3[16 +: 16] = 16'd3; b3[16 +: 16] = 16'd5; op3[2 +: 2] = 2'd2;
        req3 = 4'b0010;
        tick();
        chk("basic_gnt_c1", 32'(gnt3), 32'h2);
        chk("basic_start_c1", 32'(fu_start3), 32'h1);
        chk("basic_busy_c1", 32'(busy3), 32'h1);
        chk("basic_fu_a_c1", 32'(fu_a3), 32'd3);
        chk("basic_fu_b_c1", 32'(fu_b3), 32'd5);
        chk("basic_fu_op_c1", 32'(fu_op3), 32'd2);
        req3 = 4'b0000;
        a3[16 +: 16] = 16'd100; b3[16 +: 16] = 16'd200;
        tick();
        chk("basic_gnt_c2", 32'(gnt3), 32'h0);
        chk("basic_start_c2", 32'(fu_start3), 32'h0);
        chk("basic_fu_a_c2", 32'(fu_a3), 32'd3);
        tick();
        chk("basic_fu_b_c3", 32'(fu_b3), 32'd5);
        chk("basic_rv_c3", 32'(res_valid3), 32'h0);
        chk("basic_busy_c3", 32'(busy3), 32'h1);
        tick();
        chk("basic_rv_c4", 32'(res_valid3), 32'h2);
        chk("basic_data_c4", 32'(res_data3), 32'd15);
        chk("basic_busy_c4", 32'(busy3), 32'h0);
        tick();
        chk("basic_rv_c5", 32'(res_valid3), 32'h0);
        chk("basic_hold_c5", 32'(res_data3), 32'd15);

        // Simultaneous requests after reset: grants 0,1,2,3 every 4 cycles
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a3[i*16 +: 16] = 16'(i + 2);
            b3[i*16 +: 16] = 16'(i + 10);
        end
        req3 = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            oh = 4'b0001 << k;
            tick();
            chk($sformatf("sim_gnt%0d", k), 32'(gnt3), 32'(oh));
            req3[k] = 1'b0;
            tick(); tick(); tick();
            chk($sformatf("sim_rv%0d", k), 32'(res_valid3), 32'(oh));
            chk($sformatf("sim_data%0d", k), 32'(res_data3), 32'((k + 2) * (k + 10)));
        end

        // Fairness: 0 and 2 keep requesting, they alternate
        req3 = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            oh = 4'b0001 << order[k];
            tick();
            chk($sformatf("fair_gnt%0d", k), 32'(gnt3), 32'(oh));
            tick(); tick(); tick();
            chk($sformatf("fair_rv%0d", k), 32'(res_valid3), 32'(oh));
        end
        req3 = 4'b0000;

        // Late request: req3 rises during an EXEC owned by 0
        tick();
        req3 = 4'b0001;
        tick();
        chk("late_gnt_c1", 32'(gnt3), 32'h1);
        req3 = 4'b0000;
        tick();
        req3 = 4'b1000;
        chk("late_gnt_c2", 32'(gnt3), 32'h0);
        tick();
        chk("late_gnt_c3", 32'(gnt3), 32'h0);
        chk("late_busy_c3", 32'(busy3), 32'h1);
        tick();
        chk("late_gnt_c4", 32'(gnt3), 32'h0);
        chk("late_busy_c4", 32'(busy3), 32'h0);
        chk("late_rv_c4", 32'(res_valid3), 32'h1);
        tick();
        chk("late_gnt_c5", 32'(gnt3), 32'h8);
        chk("late_busy_c5", 32'(busy3), 32'h1);
        req3 = 4'b0000;
        tick(); tick(); tick();
        chk("late_rv_c8", 32'(res_valid3), 32'h8);

        // Advance ptr to 1, then reset in the middle of an op owned by 2
        req3 = 4'b0001;
        tick();
        req3 = 4'b0000;
        tick(); tick(); tick();
        chk("pre_rst_rv", 32'(res_valid3), 32'h1);
        req3 = 4'b0100;
        tick();
        chk("rstmid_gnt_c1", 32'(gnt3), 32'h4);
        req3 = 4'b0000;
        tick();
        rst_n = 1'b0;
        tick();
        chk("rstmid_busy", 32'(busy3), 32'h0);
        chk("rstmid_rv", 32'(res_valid3), 32'h0);
        chk("rstmid_fu_a", 32'(fu_a3), 32'h0);
        chk("rstmid_res_data", 32'(res_data3), 32'h0);
        rst_n = 1'b1;
        req3 = 4'b1001;
        tick();
        chk("rstmid_regnt", 32'(gnt3), 32'h1);
        chk("rstmid_no_rv", 32'(res_valid3), 32'h0);
        req3 = 4'b0000;
        tick(); tick(); tick();
        chk("rstmid_rv_after", 32'(res_valid3), 32'h1);

        // FU_LAT=1 with a combinational adder
        a1[32 +: 16] = 16'd7; b1[32 +: 16] = 16'd9;
        req1 = 4'b0100;
        tick();
        chk("lat1_gnt_c1", 32'(gnt1), 32'h4);
        chk("lat1_start_c1", 32'(fu_start1), 32'h1);
        chk("lat1_rv_c1", 32'(res_valid1), 32'h0);
        req1 = 4'b0000;
        tick();
        chk("lat1_rv_c2", 32'(res_valid1), 32'h4);
        chk("lat1_data_c2", 32'(res_data1), 32'd16);
        chk("lat1_busy_c2", 32'(busy1), 32'h0);
        chk("lat1_gnt_c2", 32'(gnt1), 32'h0);

        // Withdrawn request pulse during busy is never granted
        req1 = 4'b0100;
        tick();
        chk("wd_gnt_c1", 32'(gnt1), 32'h4);
        req1 = 4'b0001;
        tick();
        req1 = 4'b0000;
        tick();
        chk("wd_gnt_c3", 32'(gnt1), 32'h0);
        tick();
        chk("wd_gnt_c4", 32'(gnt1), 32'h0);
        chk("wd_busy_c4", 32'(busy1), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
